// File: rtl/instr_fetch_if.sv
// Fetch-unit bus: sequencing controls, program-memory port and decode handshake.
// slave  = the fetch unit itself.
// master = whatever drives it (core control, memory and decode stage).
interface instr_fetch_if #(
    parameter int ADDR_W = 9,
    parameter int DATA_W = 16
);
    // Sequencing controls
    logic              start;
    logic              halt;
    logic              redirect;
    logic [ADDR_W-1:0] redirect_addr;

    // Program memory port
    logic              mem_read;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_dout;

    // Decode handshake
    logic [DATA_W-1:0] instr;
    logic [ADDR_W-1:0] instr_pc;
    logic              instr_valid;
    logic              instr_ready;

    // Status
    logic [ADDR_W-1:0] pc;
    logic              busy;

    modport slave (
        input  start, halt, redirect, redirect_addr, mem_dout, instr_ready,
        output mem_read, mem_addr, instr, instr_pc, instr_valid, pc, busy
    );

    modport master (
        output start, halt, redirect, redirect_addr, mem_dout, instr_ready,
        input  mem_read, mem_addr, instr, instr_pc, instr_valid, pc, busy
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit for a 512x16 synchronous-read program memory.
// One fetch is in flight at a time: FETCH issues the read, CAPTURE latches
// the returned word, and HOLD presents it to decode until it is accepted.
// Throughput is therefore one instruction every three cycles.
// Redirect and halt can abort a fetch from any busy state.
module instr_fetch_unit #(
    parameter int          ADDR_W   = 9,
    parameter int          DATA_W   = 16,
    parameter int unsigned RESET_PC = 0
) (
    input logic            clk,
    input logic            rst,
    instr_fetch_if.slave   bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FETCH   = 2'd1,
        CAPTURE = 2'd2,
        HOLD    = 2'd3
    } state_e;

    localparam logic [ADDR_W-1:0] PC_RST = ADDR_W'(RESET_PC);

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
    logic [DATA_W-1:0] instr_q, instr_d;

    // A busy state is aborted when halt or redirect is seen; the in-flight
    // word is then dropped rather than latched.
    logic abort;
    assign abort = bus.halt || bus.redirect;

    // State, pc and captured instruction registers; reset applies immediately.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            pc_q       <= PC_RST;
            instr_q    <= '0;
            instr_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            instr_q    <= instr_d;
            instr_pc_q <= instr_pc_d;
        end
    end

    // Next-state, pc and capture logic.
    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        instr_d    = instr_q;
        instr_pc_d = instr_pc_q;

        // A redirect always reloads pc, in every state, even alongside halt.
        if (bus.redirect) begin
            pc_d = bus.redirect_addr;
        end

        case (state_q)
            IDLE: begin
                // halt overrides start.
                if (bus.start && !bus.halt) begin
                    state_d = FETCH;
                end
            end
            FETCH: begin
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Memory data for the read issued in FETCH is on mem_dout now.
                if (!abort) begin
                    instr_d    = bus.mem_dout;
                    instr_pc_d = pc_q;
                    pc_d       = pc_q + 1'b1;   // wraps modulo 2^ADDR_W
                end
                state_d = HOLD;
            end
            HOLD: begin
                if (bus.instr_ready) begin
                    state_d = FETCH;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Abort handling for busy states: halt wins over redirect's restart.
        if (state_q != IDLE) begin
            if (bus.halt) begin
                state_d = IDLE;
            end else if (bus.redirect) begin
                state_d = FETCH;
            end
        end
    end

    // Outputs are pure functions of the registered state, so reset
    // drives them to their idle values without waiting for a clock.
    assign bus.mem_read    = (state_q == FETCH);
    assign bus.mem_addr    = pc_q;
    assign bus.pc          = pc_q;
    assign bus.instr_valid = (state_q == HOLD);
    assign bus.busy        = (state_q != IDLE);
    assign bus.instr       = instr_q;
    assign bus.instr_pc    = instr_pc_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed scenarios with literal
// expectations, then randomized control traffic against a behavioural model.
module tb_instr_fetch_unit;

    localparam int ADDR_W = 9;
    localparam int DATA_W = 16;

    logic clk;
    logic rst;

    instr_fetch_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .RESET_PC(0)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    int tests;
    int fails;

    logic [DATA_W-1:0] mem [512];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program memory: synchronous read, data valid the cycle after mem_read.
    always @(posedge clk) begin
        if (bus.mem_read) bus.mem_dout <= mem[bus.mem_addr];
    end

    // Behavioural model: a fetch is "active" and has an age counted in
    // cycles since its read was issued; ages 0,1 are in flight, 2 is held.
    logic              m_active;
    int                m_age;
    logic [ADDR_W-1:0] m_pc;
    logic [DATA_W-1:0] m_instr;
    logic [ADDR_W-1:0] m_ipc;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active <= 1'b0;
            m_age    <= 0;
            m_pc     <= '0;
            m_instr  <= '0;
            m_ipc    <= '0;
        end else begin
            if (bus.redirect) m_pc <= bus.redirect_addr;
            if (!m_active) begin
                if (bus.start && !bus.halt) begin
                    m_active <= 1'b1;
                    m_age    <= 0;
                end
            end else if (bus.halt) begin
                m_active <= 1'b0;
            end else if (bus.redirect) begin
                m_age <= 0;
            end else if (m_age == 0) begin
                m_age <= 1;
            end else if (m_age == 1) begin
                m_instr <= mem[m_pc];
                m_ipc   <= m_pc;
                m_pc    <= m_pc + 1'b1;
                m_age   <= 2;
            end else if (bus.instr_ready) begin
                m_age <= 0;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        chk("cmp_mem_read", 32'(bus.mem_read), 32'(m_active && m_age == 0));
        chk("cmp_mem_addr", 32'(bus.mem_addr), 32'(m_pc));
        chk("cmp_pc", 32'(bus.pc), 32'(m_pc));
        chk("cmp_busy", 32'(bus.busy), 32'(m_active));
        chk("cmp_valid", 32'(bus.instr_valid), 32'(m_active && m_age == 2));
        chk("cmp_instr", 32'(bus.instr), 32'(m_instr));
        chk("cmp_instr_pc", 32'(bus.instr_pc), 32'(m_ipc));
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic s, input logic h, input logic r,
                          input logic [ADDR_W-1:0] ra, input logic rdy);
        bus.start         = s;
        bus.halt          = h;
        bus.redirect      = r;
        bus.redirect_addr = ra;
        bus.instr_ready   = rdy;
    endtask

    initial begin
        tests = 0;
        fails = 0;
        for (int i = 0; i < 512; i++) mem[i] = DATA_W'($urandom());
        mem[0]     = 16'h1234;
        mem[1]     = 16'hABCD;
        mem[9'h1F0] = 16'h5A5A;
        mem[511]   = 16'h7777;
        mem[9'h040] = 16'hC0DE;

        rst = 1'b1;
        set_in(0, 0, 0, '0, 0);
        tick; tick;
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_pc", 32'(bus.pc), 0);
        chk("rst_valid", 32'(bus.instr_valid), 0);
        chk("rst_instr", 32'(bus.instr), 0);
        chk("rst_mem_read", 32'(bus.mem_read), 0);
        rst = 1'b0;
        tick;

        // First fetch with decode stalled, then released.
        set_in(1, 0, 0, '0, 0);
        tick;
        bus.start = 1'b0;
        chk("lat_fetch_rd", 32'(bus.mem_read), 1);
        chk("lat_fetch_addr", 32'(bus.mem_addr), 0);
        tick;
        chk("lat_capture_rd", 32'(bus.mem_read), 0);
        chk("lat_capture_vld", 32'(bus.instr_valid), 0);
        tick;
        chk("w0_valid", 32'(bus.instr_valid), 1);
        chk("w0_instr", 32'(bus.instr), 32'h1234);
        chk("w0_ipc", 32'(bus.instr_pc), 0);
        for (int i = 0; i < 5; i++) begin
            tick;
            chk("stall_valid", 32'(bus.instr_valid), 1);
            chk("stall_instr", 32'(bus.instr), 32'h1234);
            chk("stall_rd", 32'(bus.mem_read), 0);
            chk("stall_pc", 32'(bus.pc), 1);
        end
        bus.instr_ready = 1'b1;
        tick;
        chk("w1_fetch_addr", 32'(bus.mem_addr), 1);
        chk("w1_fetch_vld", 32'(bus.instr_valid), 0);
        tick; tick;
        chk("w1_instr", 32'(bus.instr), 32'hABCD);
        chk("w1_ipc", 32'(bus.instr_pc), 1);

        // Redirect during CAPTURE discards the word at address 2.
        tick; tick;
        bus.redirect = 1'b1; bus.redirect_addr = 9'h1F0;
        tick;
        bus.redirect = 1'b0;
        chk("redir_vld", 32'(bus.instr_valid), 0);
        chk("redir_addr", 32'(bus.mem_addr), 32'h1F0);
        chk("redir_rd", 32'(bus.mem_read), 1);
        tick; tick;
        chk("redir_instr", 32'(bus.instr), 32'h5A5A);
        chk("redir_ipc", 32'(bus.instr_pc), 32'h1F0);

        // halt + redirect to the top address, then wrap.
        set_in(0, 1, 1, 9'd511, 1);
        tick;
        chk("hr_busy", 32'(bus.busy), 0);
        chk("hr_pc", 32'(bus.pc), 511);
        set_in(1, 0, 0, '0, 1);
        tick;
        bus.start = 1'b0;
        chk("wrap_fetch_addr", 32'(bus.mem_addr), 511);
        tick; tick;
        chk("wrap_instr", 32'(bus.instr), 32'h7777);
        chk("wrap_ipc", 32'(bus.instr_pc), 511);
        chk("wrap_pc", 32'(bus.pc), 0);
        tick;
        chk("wrap_next_addr", 32'(bus.mem_addr), 0);
        chk("wrap_next_rd", 32'(bus.mem_read), 1);
        tick; tick;

        // halt + redirect(0x040) in HOLD, then restart from 0x040.
        set_in(0, 1, 1, 9'h040, 1);
        tick;
        chk("hr2_busy", 32'(bus.busy), 0);
        chk("hr2_valid", 32'(bus.instr_valid), 0);
        chk("hr2_pc", 32'(bus.pc), 32'h040);
        chk("hr2_instr_kept", 32'(bus.instr), 32'h1234);
        set_in(1, 0, 0, '0, 1);
        tick;
        bus.start = 1'b0;
        chk("hr2_fetch_addr", 32'(bus.mem_addr), 32'h040);
        tick; tick;
        chk("hr2_instr", 32'(bus.instr), 32'hC0DE);

        // Asynchronous reset in the middle of a FETCH cycle.
        tick;
        chk("ar_pre_rd", 32'(bus.mem_read), 1);
        #2 rst = 1'b1;
        #1;
        chk("ar_rd", 32'(bus.mem_read), 0);
        chk("ar_busy", 32'(bus.busy), 0);
        chk("ar_pc", 32'(bus.pc), 0);
        chk("ar_instr", 32'(bus.instr), 0);
        chk("ar_ipc", 32'(bus.instr_pc), 0);
        chk("ar_valid", 32'(bus.instr_valid), 0);
        tick;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick;
            chk("post_rst_idle", 32'(bus.busy), 0);
        end

        // Randomized control traffic, checked by the per-cycle compare.
        for (int i = 0; i < 4000; i++) begin
            set_in(($urandom_range(3) == 0), ($urandom_range(15) == 0),
                   ($urandom_range(9) == 0), ADDR_W'($urandom()),
                   ($urandom_range(1) == 1));
            rst = ($urandom_range(499) == 0);
            tick;
        end
        rst = 1'b0;
        set_in(0, 0, 0, '0, 0);
        tick; tick;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
